// File: rtl/cam_uart_bridge.sv
// UART command/status bridge between the host serial link and NUM_CAMS camera managers.
// Optional RX echo of every captured byte: define CAM_UART_ECHO_EN.
module cam_uart_bridge #(
  parameter int NUM_CAMS   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                bicR,
  input  logic [3:0]                bicS,
  input  logic [7:0]                dataIn,
  output logic [7:0]                dataOut,
  output logic                      transmit,
  output logic                      load,
  output logic                      cmd_start,
  output logic [NUM_CAMS-1:0]       cmd_download,
  input  logic [NUM_CAMS-1:0]       cam_rtd,
  input  logic [NUM_CAMS-1:0]       cam_busy,
  input  logic [NUM_CAMS*CNT_W-1:0] cam_count,
  output logic                      tx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {P_IDLE, P_IDX} pstate_t;
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_ARM, T_SEND, T_WAIT} tstate_t;

  pstate_t pstate, pstate_n;
  tstate_t tstate, tstate_n;

  logic                bicr9_q;
  logic                rx_valid;
  logic [7:0]          idx;
  logic                cmd_start_n;
  logic [NUM_CAMS-1:0] dl_n;
  logic                err_set;

  logic                err_pend, err_clr;
  logic [NUM_CAMS-1:0] rtd_prev, rtd_set, rtd_pend, rtd_clr;
  logic [NUM_CAMS-1:0] cnt_diff, cnt_pend, cnt_clr;
  logic [CNT_W-1:0]    last_sent [NUM_CAMS];
  logic                found;
  logic                ovf_hit;

  logic                push, pop, can_push, full, empty;
  logic [7:0]          push_data, head;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [7:0]          mem [FIFO_DEPTH];

  logic [7:0]          dout_n;
  logic                load_n, tx_n;

`ifdef CAM_UART_ECHO_EN
  logic                echo_pend, echo_clr;
  logic [7:0]          echo_byte;
`endif

  // A byte is taken only on the first cycle bicR reads 9.
  assign rx_valid = (bicR == 4'd9) && !bicr9_q;
  assign idx      = dataIn - 8'h30;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bicr9_q      <= 1'b0;
      pstate       <= P_IDLE;
      cmd_start    <= 1'b0;
      cmd_download <= '0;
    end else begin
      bicr9_q      <= (bicR == 4'd9);
      pstate       <= pstate_n;
      cmd_start    <= cmd_start_n;
      cmd_download <= dl_n;
    end
  end

  always_comb begin
    pstate_n    = pstate;
    cmd_start_n = 1'b0;
    dl_n        = cmd_download;
    err_set     = 1'b0;
    if (rx_valid) begin
      case (pstate)
        P_IDLE: begin
          if (dataIn == 8'h73)      cmd_start_n = 1'b1;
          else if (dataIn == 8'h64) pstate_n = P_IDX;
          else                      err_set = 1'b1;
        end
        P_IDX: begin
          pstate_n = P_IDLE;
          if (idx < 8'(NUM_CAMS)) begin
            for (int unsigned k = 0; k < NUM_CAMS; k++) dl_n[k] = (idx == 8'(k));
          end else begin
            err_set = 1'b1;
          end
        end
      endcase
    end
  end

  assign rtd_set = cam_rtd & ~rtd_prev;

  always_comb begin
    for (int unsigned k = 0; k < NUM_CAMS; k++)
      cnt_diff[k] = cam_busy[k] && (cam_count[k*CNT_W +: CNT_W] != last_sent[k]);
  end

  // Fixed-priority arbiter; a pop this cycle frees a slot in a full FIFO.
  assign can_push = !full || pop;

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    err_clr   = 1'b0;
    rtd_clr   = '0;
    cnt_clr   = '0;
    found     = 1'b0;
`ifdef CAM_UART_ECHO_EN
    echo_clr  = 1'b0;
`endif
    if (can_push) begin
`ifdef CAM_UART_ECHO_EN
      if (echo_pend) begin
        echo_clr  = 1'b1;
        push      = 1'b1;
        push_data = echo_byte;
      end else
`endif
      if (err_pend) begin
        err_clr   = 1'b1;
        push      = 1'b1;
        push_data = 8'h3F;
      end else begin
        for (int unsigned k = 0; k < NUM_CAMS; k++) begin
          if (!found && rtd_pend[k]) begin
            found      = 1'b1;
            rtd_clr[k] = 1'b1;
            push_data  = 8'h67 + 8'(k);
          end
        end
        for (int unsigned k = 0; k < NUM_CAMS; k++) begin
          if (!found && cnt_pend[k]) begin
            found      = 1'b1;
            cnt_clr[k] = 1'b1;
            push_data  = 8'h30 + 8'(cam_count[k*CNT_W +: CNT_W]);
          end
        end
        push = found;
      end
    end
  end

  always_comb begin
    ovf_hit = (err_set && err_pend && !err_clr) || (|(rtd_set & rtd_pend & ~rtd_clr));
`ifdef CAM_UART_ECHO_EN
    ovf_hit = ovf_hit || (rx_valid && echo_pend && !echo_clr);
`endif
  end

  // A flag raised in its own push cycle survives; cnt_pend is dropped on push because the pushed value is current.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_pend <= 1'b0;
      rtd_prev <= '0;
      rtd_pend <= '0;
      cnt_pend <= '0;
      tx_ovf   <= 1'b0;
      for (int unsigned k = 0; k < NUM_CAMS; k++) last_sent[k] <= '0;
    end else begin
      err_pend <= err_set || (err_pend && !err_clr);
      rtd_prev <= cam_rtd;
      rtd_pend <= rtd_set | (rtd_pend & ~rtd_clr);
      cnt_pend <= ~cnt_clr & (cnt_diff | cnt_pend);
      if (ovf_hit) tx_ovf <= 1'b1;
      for (int unsigned k = 0; k < NUM_CAMS; k++)
        if (cnt_clr[k]) last_sent[k] <= cam_count[k*CNT_W +: CNT_W];
    end
  end

`ifdef CAM_UART_ECHO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_pend <= 1'b0;
      echo_byte <= '0;
    end else begin
      echo_pend <= rx_valid || (echo_pend && !echo_clr);
      if (rx_valid && !(echo_pend && !echo_clr)) echo_byte <= dataIn;
    end
  end
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tstate   <= T_IDLE;
      dataOut  <= 8'h2D;
      load     <= 1'b1;
      transmit <= 1'b0;
    end else begin
      tstate   <= tstate_n;
      dataOut  <= dout_n;
      load     <= load_n;
      transmit <= tx_n;
    end
  end

  // Register updates are attached to the transition into each state so data leads transmit by one cycle.
  always_comb begin
    tstate_n = tstate;
    pop      = 1'b0;
    dout_n   = dataOut;
    load_n   = load;
    tx_n     = transmit;
    case (tstate)
      T_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          dout_n   = head;
          load_n   = 1'b0;
          tstate_n = T_LOAD;
        end
      end
      T_LOAD: begin
        tx_n     = 1'b1;
        tstate_n = T_ARM;
      end
      T_ARM: tstate_n = T_SEND;
      T_SEND: begin
        if (bicS == 4'd1) begin
          tx_n     = 1'b0;
          tstate_n = T_WAIT;
        end
      end
      T_WAIT: begin
        if (bicS == 4'd0) begin
          load_n   = 1'b1;
          tstate_n = T_IDLE;
        end
      end
      default: tstate_n = T_IDLE;
    endcase
  end

endmodule
